// File: rtl/ccu_snoop_arbiter.sv
// ccu_snoop_arbiter
// Shares one AC/CR/CD snoop port between NumReq CCU snoop controllers.
// AC requests are arbitrated round-robin with grants that stay stable while
// the downstream stalls. Two small order FIFOs remember which requester owns
// each outstanding CR response and each CD burst so the returning beats can
// be steered back to the requester that issued the matching AC.
module ccu_snoop_arbiter #(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  // upstream AC, one lane per requester
  input  logic [NumReq-1:0]             req_ac_valid_i,
  output logic [NumReq-1:0]             req_ac_ready_o,
  input  logic [NumReq*AddrWidth-1:0]   req_ac_addr_i,
  input  logic [NumReq*4-1:0]           req_ac_snoop_i,
  input  logic [NumReq*3-1:0]           req_ac_prot_i,
  // upstream CR, valid steered to the owner, payload broadcast
  output logic [NumReq-1:0]             req_cr_valid_o,
  input  logic [NumReq-1:0]             req_cr_ready_i,
  output logic [4:0]                    req_cr_resp_o,
  // upstream CD, valid steered to the owner, payload broadcast
  output logic [NumReq-1:0]             req_cd_valid_o,
  input  logic [NumReq-1:0]             req_cd_ready_i,
  output logic [DataWidth-1:0]          req_cd_data_o,
  output logic                          req_cd_last_o,
  // downstream AC
  output logic                          ac_valid_o,
  input  logic                          ac_ready_i,
  output logic [AddrWidth-1:0]          ac_addr_o,
  output logic [3:0]                    ac_snoop_o,
  output logic [2:0]                    ac_prot_o,
  // downstream CR
  input  logic                          cr_valid_i,
  output logic                          cr_ready_o,
  input  logic [4:0]                    cr_resp_i,
  // downstream CD
  input  logic                          cd_valid_i,
  output logic                          cd_ready_o,
  input  logic [DataWidth-1:0]          cd_data_i,
  input  logic                          cd_last_i
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned PtrW = $clog2(MaxOutstanding);
  localparam int unsigned CntW = PtrW + 1;

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  // Next requester index after i, wrapping at NumReq (NumReq need not be a power of two).
  function automatic idx_t idx_inc(input idx_t i);
    if (i == idx_t'(NumReq - 1)) return '0;
    return i + idx_t'(1);
  endfunction

  // First valid requester found when scanning upward from ptr with wrap-around.
  function automatic idx_t rr_pick(input logic [NumReq-1:0] vld, input idx_t ptr);
    idx_t        pick;
    idx_t        ci;
    logic        found;
    int unsigned cand;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= NumReq) cand = cand - NumReq;
      ci = idx_t'(cand);
      if (!found && vld[ci]) begin
        pick  = ci;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // ---------------------------------------------------------------------------
  // Arbitration state
  // ---------------------------------------------------------------------------
  idx_t rr_ptr_q;
  logic lock_q;
  idx_t lock_idx_q;

  idx_t rr_idx;
  idx_t grant_idx;
  logic any_req;
  logic ac_hs;

  // ---------------------------------------------------------------------------
  // Order FIFOs: CR FIFO holds the AC issuer, CD FIFO holds the CR owner that
  // announced DataTransfer. Storage is not reset; only pointers and counts are.
  // ---------------------------------------------------------------------------
  idx_t cr_mem [MaxOutstanding];
  ptr_t cr_wr_q, cr_rd_q;
  cnt_t cr_cnt_q;
  logic cr_full, cr_empty;
  idx_t cr_head;
  logic cr_push, cr_pop, cr_hs;

  idx_t cd_mem [MaxOutstanding];
  ptr_t cd_wr_q, cd_rd_q;
  cnt_t cd_cnt_q;
  logic cd_full, cd_empty;
  idx_t cd_head;
  logic cd_push, cd_pop;

  assign cr_full  = (cr_cnt_q == cnt_t'(MaxOutstanding));
  assign cr_empty = (cr_cnt_q == '0);
  assign cr_head  = cr_mem[cr_rd_q];

  assign cd_full  = (cd_cnt_q == cnt_t'(MaxOutstanding));
  assign cd_empty = (cd_cnt_q == '0);
  assign cd_head  = cd_mem[cd_rd_q];

  // ---------------------------------------------------------------------------
  // AC path: combinational request-to-valid, grant frozen while locked
  // ---------------------------------------------------------------------------
  assign any_req   = |req_ac_valid_i;
  assign rr_idx    = rr_pick(req_ac_valid_i, rr_ptr_q);
  assign grant_idx = lock_q ? lock_idx_q : rr_idx;

  // No bypass at full: a pop in the same cycle does not open a slot for this AC.
  assign ac_valid_o = any_req && !cr_full;
  assign ac_hs      = ac_valid_o && ac_ready_i;

  assign ac_addr_o  = req_ac_addr_i[grant_idx*AddrWidth +: AddrWidth];
  assign ac_snoop_o = req_ac_snoop_i[grant_idx*4 +: 4];
  assign ac_prot_o  = req_ac_prot_i[grant_idx*3 +: 3];

  // Ready is returned only to the granted requester.
  always_comb begin
    req_ac_ready_o = '0;
    if (ac_hs) req_ac_ready_o[grant_idx] = 1'b1;
  end

  // Round-robin pointer advances past the winner; lock holds a stalled grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (ac_hs) begin
      rr_ptr_q   <= idx_inc(grant_idx);
      lock_q     <= 1'b0;
    end else if (ac_valid_o) begin
      lock_q     <= 1'b1;
      lock_idx_q <= grant_idx;
    end
  end

  // ---------------------------------------------------------------------------
  // CR path: steer to the oldest AC issuer; hold off a DataTransfer response
  // while there is no room to remember its CD burst owner.
  // ---------------------------------------------------------------------------
  assign cr_ready_o    = !cr_empty && req_cr_ready_i[cr_head] && !(cr_resp_i[0] && cd_full);
  assign cr_hs         = cr_valid_i && cr_ready_o;
  assign req_cr_resp_o = cr_resp_i;

  // Only the head owner may see a CR valid.
  always_comb begin
    req_cr_valid_o = '0;
    if (cr_valid_i && !cr_empty) req_cr_valid_o[cr_head] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // CD path: steer every beat to the head owner, retire the entry on last.
  // ---------------------------------------------------------------------------
  assign cd_ready_o    = !cd_empty && req_cd_ready_i[cd_head];
  assign req_cd_data_o = cd_data_i;
  assign req_cd_last_o = cd_last_i;

  // Only the owner of the current burst may see a CD valid.
  always_comb begin
    req_cd_valid_o = '0;
    if (cd_valid_i && !cd_empty) req_cd_valid_o[cd_head] = 1'b1;
  end

  assign cr_push = ac_hs;
  assign cr_pop  = cr_hs;
  assign cd_push = cr_hs && cr_resp_i[0];
  assign cd_pop  = cd_valid_i && cd_ready_o && cd_last_i;

  // CR FIFO storage write of the granted requester index.
  always_ff @(posedge clk_i) begin
    if (cr_push) cr_mem[cr_wr_q] <= grant_idx;
  end

  // CR FIFO pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cr_wr_q  <= '0;
      cr_rd_q  <= '0;
      cr_cnt_q <= '0;
    end else begin
      if (cr_push) cr_wr_q <= cr_wr_q + ptr_t'(1);
      if (cr_pop)  cr_rd_q <= cr_rd_q + ptr_t'(1);
      cr_cnt_q <= cr_cnt_q + cnt_t'(cr_push) - cnt_t'(cr_pop);
    end
  end

  // CD FIFO storage write of the CR owner that announced a data transfer.
  always_ff @(posedge clk_i) begin
    if (cd_push) cd_mem[cd_wr_q] <= cr_head;
  end

  // CD FIFO pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cd_wr_q  <= '0;
      cd_rd_q  <= '0;
      cd_cnt_q <= '0;
    end else begin
      if (cd_push) cd_wr_q <= cd_wr_q + ptr_t'(1);
      if (cd_pop)  cd_rd_q <= cd_rd_q + ptr_t'(1);
      cd_cnt_q <= cd_cnt_q + cnt_t'(cd_push) - cnt_t'(cd_pop);
    end
  end

  // ---------------------------------------------------------------------------
  // Protocol checks: beats with no outstanding owner and structural invariants
  // ---------------------------------------------------------------------------
  a_cr_without_owner: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(cr_valid_i && cr_empty));

  a_cd_without_owner: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(cd_valid_i && cd_empty));

  a_cr_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(cr_push && cr_full));

  a_cd_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(cd_push && cd_full));

  a_cr_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(req_cr_valid_o));

  a_ac_grant_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (ac_valid_o && !ac_ready_i) |=> (grant_idx == $past(grant_idx)));

endmodule

// File: tb/tb_ccu_snoop_arbiter.sv
// Testbench for ccu_snoop_arbiter: directed scenarios followed by a randomized
// phase, all checked against a queue-based reference model of the routing rules.
module tb_ccu_snoop_arbiter;

  localparam int N  = 2;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int MO = 4;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [N-1:0]      req_ac_valid_i;
  logic [N-1:0]      req_ac_ready_o;
  logic [N*AW-1:0]   req_ac_addr_i;
  logic [N*4-1:0]    req_ac_snoop_i;
  logic [N*3-1:0]    req_ac_prot_i;
  logic [N-1:0]      req_cr_valid_o;
  logic [N-1:0]      req_cr_ready_i;
  logic [4:0]        req_cr_resp_o;
  logic [N-1:0]      req_cd_valid_o;
  logic [N-1:0]      req_cd_ready_i;
  logic [DW-1:0]     req_cd_data_o;
  logic              req_cd_last_o;
  logic              ac_valid_o;
  logic              ac_ready_i;
  logic [AW-1:0]     ac_addr_o;
  logic [3:0]        ac_snoop_o;
  logic [2:0]        ac_prot_o;
  logic              cr_valid_i;
  logic              cr_ready_o;
  logic [4:0]        cr_resp_i;
  logic              cd_valid_i;
  logic              cd_ready_o;
  logic [DW-1:0]     cd_data_i;
  logic              cd_last_i;

  ccu_snoop_arbiter #(
    .NumReq(N), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_ac_valid_i(req_ac_valid_i), .req_ac_ready_o(req_ac_ready_o),
    .req_ac_addr_i(req_ac_addr_i), .req_ac_snoop_i(req_ac_snoop_i), .req_ac_prot_i(req_ac_prot_i),
    .req_cr_valid_o(req_cr_valid_o), .req_cr_ready_i(req_cr_ready_i), .req_cr_resp_o(req_cr_resp_o),
    .req_cd_valid_o(req_cd_valid_o), .req_cd_ready_i(req_cd_ready_i),
    .req_cd_data_o(req_cd_data_o), .req_cd_last_o(req_cd_last_o),
    .ac_valid_o(ac_valid_o), .ac_ready_i(ac_ready_i),
    .ac_addr_o(ac_addr_o), .ac_snoop_o(ac_snoop_o), .ac_prot_o(ac_prot_o),
    .cr_valid_i(cr_valid_i), .cr_ready_o(cr_ready_o), .cr_resp_i(cr_resp_i),
    .cd_valid_i(cd_valid_i), .cd_ready_o(cd_ready_o),
    .cd_data_i(cd_data_i), .cd_last_i(cd_last_i)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // Reference model: order of outstanding owners and arbitration history.
  int q_cr[$];
  int q_cd[$];
  int rr_ptr  = 0;
  bit locked  = 0;
  int lock_id = 0;
  bit last_ac_hs;
  int last_ac_g;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a,
                         input logic [3:0] s, input logic [2:0] p);
    req_ac_valid_i[i]        = v;
    req_ac_addr_i[i*AW +: AW] = a;
    req_ac_snoop_i[i*4 +: 4] = s;
    req_ac_prot_i[i*3 +: 3]  = p;
  endtask

  task automatic model_reset();
    q_cr.delete();
    q_cd.delete();
    rr_ptr = 0;
    locked = 0;
    lock_id = 0;
  endtask

  // Check all outputs against the model mid-cycle, then advance the model
  // by the handshakes it expects to happen at the coming edge.
  task automatic cycle();
    int g, head, cdh, c;
    bit acv, crr, cdr, cr_hs, cd_end;
    logic [N-1:0] e_acr, e_crv, e_cdv;
    #4;
    g = -1;
    if (locked) g = lock_id;
    else for (int k = 0; k < N; k++) begin
      c = (rr_ptr + k) % N;
      if (g < 0 && req_ac_valid_i[c]) g = c;
    end
    acv = (req_ac_valid_i != '0) && (q_cr.size() < MO);
    e_acr = '0;
    if (acv && ac_ready_i) e_acr[g] = 1'b1;
    chk("ac_valid", 64'(ac_valid_o), 64'(acv));
    chk("req_ac_ready", 64'(req_ac_ready_o), 64'(e_acr));
    if (acv) begin
      chk("ac_addr", ac_addr_o, req_ac_addr_i[g*AW +: AW]);
      chk("ac_snoop", 64'(ac_snoop_o), 64'(req_ac_snoop_i[g*4 +: 4]));
      chk("ac_prot", 64'(ac_prot_o), 64'(req_ac_prot_i[g*3 +: 3]));
    end
    head = (q_cr.size() > 0) ? q_cr[0] : -1;
    e_crv = '0;
    crr = 0;
    if (head >= 0) begin
      if (cr_valid_i) e_crv[head] = 1'b1;
      crr = req_cr_ready_i[head] && !(cr_resp_i[0] && q_cd.size() == MO);
    end
    chk("req_cr_valid", 64'(req_cr_valid_o), 64'(e_crv));
    chk("cr_ready", 64'(cr_ready_o), 64'(crr));
    chk("req_cr_resp", 64'(req_cr_resp_o), 64'(cr_resp_i));
    cdh = (q_cd.size() > 0) ? q_cd[0] : -1;
    e_cdv = '0;
    cdr = 0;
    if (cdh >= 0) begin
      if (cd_valid_i) e_cdv[cdh] = 1'b1;
      cdr = req_cd_ready_i[cdh];
    end
    chk("req_cd_valid", 64'(req_cd_valid_o), 64'(e_cdv));
    chk("cd_ready", 64'(cd_ready_o), 64'(cdr));
    chk("req_cd_data", req_cd_data_o, cd_data_i);
    chk("req_cd_last", 64'(req_cd_last_o), 64'(cd_last_i));
    last_ac_hs = acv && ac_ready_i;
    last_ac_g  = g;
    cr_hs  = cr_valid_i && crr;
    cd_end = cd_valid_i && cdr && cd_last_i;
    if (last_ac_hs) begin
      q_cr.push_back(g);
      rr_ptr = (g + 1) % N;
      locked = 0;
    end else if (acv) begin
      locked = 1;
      lock_id = g;
    end
    if (cd_end) void'(q_cd.pop_front());
    if (cr_hs) begin
      if (cr_resp_i[0]) q_cd.push_back(head);
      void'(q_cr.pop_front());
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain_cr(input logic [4:0] resp);
    int n = 0;
    cr_valid_i = 1'b1;
    cr_resp_i = resp;
    req_cr_ready_i = '1;
    while (q_cr.size() > 0 && n < 20) begin
      cycle();
      n++;
    end
    cr_valid_i = 1'b0;
  endtask

  task automatic drain_cd();
    int n = 0;
    cd_valid_i = 1'b1;
    cd_last_i = 1'b1;
    req_cd_ready_i = '1;
    while (q_cd.size() > 0 && n < 20) begin
      cd_data_i = {$urandom, $urandom};
      cycle();
      n++;
    end
    cd_valid_i = 1'b0;
    cd_last_i = 1'b0;
  endtask

  logic [N-1:0] exp_seq [6];

  initial begin
    rst_ni = 1'b0;
    req_ac_valid_i = '0; req_ac_addr_i = '0; req_ac_snoop_i = '0; req_ac_prot_i = '0;
    req_cr_ready_i = '1; req_cd_ready_i = '1; ac_ready_i = 1'b1;
    cr_valid_i = 1'b0; cr_resp_i = '0; cd_valid_i = 1'b0; cd_data_i = '0; cd_last_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_ac_valid", 64'(ac_valid_o), 64'd0);
    chk("rst_req_ac_ready", 64'(req_ac_ready_o), 64'd0);
    chk("rst_cr_ready", 64'(cr_ready_o), 64'd0);
    chk("rst_cd_ready", 64'(cd_ready_o), 64'd0);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Single requester 1, same-cycle AC, CR routed only to requester 1
    set_req(1, 1'b1, 64'h1000, 4'h7, 3'h2);
    #1;
    chk("t1_ac_addr", ac_addr_o, 64'h1000);
    chk("t1_ac_snoop", 64'(ac_snoop_o), 64'h7);
    chk("t1_req_ac_ready", 64'(req_ac_ready_o), 64'b10);
    cycle();
    req_ac_valid_i = '0;
    cr_valid_i = 1'b1; cr_resp_i = 5'h00;
    #1;
    chk("t1_req_cr_valid", 64'(req_cr_valid_o), 64'b10);
    cycle();
    cr_valid_i = 1'b0;

    // Both requesters every cycle: alternating grants until the CR FIFO fills
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01;
    exp_seq[3] = 2'b10; exp_seq[4] = 2'b00; exp_seq[5] = 2'b00;
    set_req(0, 1'b1, 64'hA000, 4'h1, 3'h0);
    set_req(1, 1'b1, 64'hB000, 4'h2, 3'h1);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("t2_grant_seq", 64'(req_ac_ready_o), 64'(exp_seq[i]));
      cycle();
    end
    cr_valid_i = 1'b1; cr_resp_i = 5'h00;
    #1;
    chk("t2_full_pop_no_bypass", 64'(ac_valid_o), 64'd0);
    cycle();
    cr_valid_i = 1'b0;
    #1;
    chk("t2_after_pop_valid", 64'(ac_valid_o), 64'd1);
    cycle();
    req_ac_valid_i = '0;
    drain_cr(5'h00);

    // Grant 0 stalled while requester 1 arrives: payload and grant held
    ac_ready_i = 1'b0;
    set_req(0, 1'b1, 64'hC0C0, 4'h3, 3'h4);
    cycle();
    set_req(1, 1'b1, 64'hD0D0, 4'h5, 3'h5);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_locked_addr", ac_addr_o, 64'hC0C0);
      cycle();
    end
    ac_ready_i = 1'b1;
    #1;
    chk("t3_hs_ready", 64'(req_ac_ready_o), 64'b01);
    cycle();
    req_ac_valid_i[0] = 1'b0;
    #1;
    chk("t3_next_grant", 64'(req_ac_ready_o), 64'b10);
    chk("t3_next_addr", ac_addr_o, 64'hD0D0);
    cycle();
    req_ac_valid_i = '0;
    drain_cr(5'h00);

    // req0 then req1; DataTransfer on first CR; 4-beat burst to req0 only
    set_req(0, 1'b1, 64'h2000, 4'h1, 3'h0);
    cycle();
    req_ac_valid_i[0] = 1'b0;
    set_req(1, 1'b1, 64'h3000, 4'h1, 3'h0);
    cycle();
    req_ac_valid_i = '0;
    cr_valid_i = 1'b1; cr_resp_i = 5'h01;
    #1;
    chk("t4_cr0_route", 64'(req_cr_valid_o), 64'b01);
    cycle();
    cr_resp_i = 5'h00;
    #1;
    chk("t4_cr1_route", 64'(req_cr_valid_o), 64'b10);
    cycle();
    cr_valid_i = 1'b0;
    for (int b = 0; b < 4; b++) begin
      cd_valid_i = 1'b1;
      cd_last_i = (b == 3);
      cd_data_i = {$urandom, $urandom};
      #1;
      chk("t4_cd_route", 64'(req_cd_valid_o), 64'b01);
      chk("t4_cd_last", 64'(req_cd_last_o), 64'(b == 3));
      cycle();
    end
    cd_valid_i = 1'b0; cd_last_i = 1'b0;

    // CD FIFO full: a DataTransfer CR waits for one CD last handshake
    set_req(0, 1'b1, 64'h4000, 4'h0, 3'h0);
    repeat (4) cycle();
    req_ac_valid_i = '0;
    drain_cr(5'h01);
    req_ac_valid_i[0] = 1'b1;
    cycle();
    req_ac_valid_i = '0;
    cr_valid_i = 1'b1; cr_resp_i = 5'h01;
    #1;
    chk("t5_cr_blocked", 64'(cr_ready_o), 64'd0);
    cycle();
    cycle();
    cd_valid_i = 1'b1; cd_last_i = 1'b1;
    #1;
    chk("t5_cr_blocked_during_pop", 64'(cr_ready_o), 64'd0);
    chk("t5_cd_ready", 64'(cd_ready_o), 64'd1);
    cycle();
    cd_valid_i = 1'b0; cd_last_i = 1'b0;
    #1;
    chk("t5_cr_accepted", 64'(cr_ready_o), 64'd1);
    cycle();
    cr_valid_i = 1'b0;
    drain_cd();

    // Reset with two outstanding ACs and a non-zero round-robin pointer
    set_req(1, 1'b1, 64'h5000, 4'h0, 3'h0);
    cycle();
    req_ac_valid_i = '0;
    set_req(0, 1'b1, 64'h6000, 4'h0, 3'h0);
    cycle();
    req_ac_valid_i = '0;
    ac_ready_i = 1'b1; req_cr_ready_i = '1; req_cd_ready_i = '1;
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_ac_valid", 64'(ac_valid_o), 64'd0);
    chk("t6_rst_req_ac_ready", 64'(req_ac_ready_o), 64'd0);
    chk("t6_rst_cr_ready", 64'(cr_ready_o), 64'd0);
    chk("t6_rst_cd_ready", 64'(cd_ready_o), 64'd0);
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    set_req(0, 1'b1, 64'h7000, 4'h0, 3'h0);
    set_req(1, 1'b1, 64'h8000, 4'h0, 3'h0);
    #1;
    chk("t6_grant_after_reset", 64'(req_ac_ready_o), 64'b01);
    cycle();
    req_ac_valid_i = '0;
    drain_cr(5'h00);

    // Randomized traffic with AXI-compliant requesters
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if (!req_ac_valid_i[i] && $urandom_range(0, 2) == 0)
          set_req(i, 1'b1, {$urandom, $urandom}, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
      ac_ready_i     = 1'($urandom_range(0, 1));
      cr_valid_i     = (q_cr.size() > 0) && ($urandom_range(0, 1) == 1);
      cr_resp_i      = 5'($urandom);
      req_cr_ready_i = N'($urandom);
      cd_valid_i     = (q_cd.size() > 0) && ($urandom_range(0, 1) == 1);
      cd_data_i      = {$urandom, $urandom};
      cd_last_i      = ($urandom_range(0, 2) == 0);
      req_cd_ready_i = N'($urandom);
      cycle();
      if (last_ac_hs) req_ac_valid_i[last_ac_g] = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
